repdiv_unit: RTL
================

Name: repdiv_unit

Overview:
- Repeated-subtraction unsigned divider with an integrated FSM and datapath. It is the inverse companion of the team's repeated-addition multiplier.
- Operands arrive sequentially on one shared input bus: dividend first, then divisor.
- The quotient is counted up while the divisor is subtracted from a working remainder.
- Completion is signalled with a start/done handshake to the enclosing top level.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled in IDLE and DONE.
- data_in  input  WIDTH  operand bus: dividend during LDA, divisor during LDB.
- quotient  output  WIDTH  quotient register; valid while done=1.
- remainder  output  WIDTH  working/remainder register; valid while done=1.
- busy  output  1  high in LDA, LDB and SUB.
- done  output  1  high only in DONE.
- div_by_zero  output  1  high in DONE when the captured divisor was 0.

Behaviour:
- Reset: rst=1 asynchronously forces:
  - state=IDLE;
  - quotient, remainder, internal divisor register = 0;
  - busy, done, div_by_zero = 0.
  - This applies from any state, including mid-SUB. Operation resumes from IDLE after rst is released.
- Outputs are Moore: busy, done and div_by_zero decode from state and registers only. No combinational path from start.
- State encoding: 3 bits. IDLE=0, LDA=1, LDB=2, SUB=3, DONE=4. Unused codes go to IDLE on the next edge.
- IDLE: start=1 -> LDA, otherwise stay. Registers hold their last values.
- LDA: at the edge leaving LDA, remainder <= data_in. Always -> LDB.
- LDB:
  - At the exit edge, divisor <= data_in and quotient <= 0.
  - If data_in==0 -> DONE, with div_by_zero set, quotient <= all ones, remainder keeps the dividend.
  - Otherwise div_by_zero <= 0 -> SUB.
- SUB, per edge:
  - if remainder >= divisor: remainder <= remainder - divisor, quotient <= quotient + 1, stay in SUB;
  - else -> DONE with no register change.
- Arithmetic: unsigned, WIDTH bits. The subtraction cannot underflow because it is guarded by the compare. The quotient never exceeds 2^WIDTH-1 (worst case divisor=1), so it never wraps.
- DONE:
  - done=1; quotient, remainder and div_by_zero are held stable.
  - Stay while start=1. start=0 -> IDLE.
  - A new operation therefore needs start to drop and rise again (level start, no auto-retrigger).
- start is ignored in LDA, LDB and SUB.
- data_in matters only during LDA and LDB and may change freely at other times.
- Latency: from the edge sampling start=1 in IDLE, done rises after Q+3 edges for a nonzero divisor (Q = quotient), or after 2 edges for a zero divisor.
- busy and done are never both high. In IDLE both are 0.

Optional Feature:
- Macro: REPDIV_ITER_COUNT_EN.
- When defined:
  - an extra output port iter_count [WIDTH:0] is added;
  - it is cleared to 0 at the LDB exit edge and on rst;
  - it increments on every SUB edge, including the exiting edge;
  - it holds in DONE, so iter_count = Q+1 for a nonzero divisor and 0 for a zero divisor.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- 13/4, WIDTH=8:
  - start=1, data_in=13 in LDA, 4 in LDB;
  - expect done=1 exactly 6 edges after the start edge, quotient=3, remainder=1, div_by_zero=0;
  - iter_count=4 if enabled.
- 3/7:
  - expect done after 3 edges, quotient=0, remainder=3, busy high for 3 cycles.
- 200/0:
  - expect done after 2 edges, div_by_zero=1, quotient=8'hFF, remainder=200.
- 255/1:
  - expect done after 258 edges, quotient=255, remainder=0, no wrap.
- Reset mid-op, 100/3:
  - assert rst for one cycle while in SUB (e.g. 10 edges after start);
  - expect all outputs 0 and state IDLE immediately;
  - then 100/3 rerun -> quotient=33, remainder=1.
- Handshake:
  - hold start=1 through DONE -> stays DONE, outputs stable;
  - drop start -> done=0 next edge;
  - re-raise start -> new 9/9 run gives quotient=1, remainder=0.

Source files
------------

// File: rtl/repdiv_unit.sv
// repdiv_unit: repeated-subtraction unsigned divider.
// The dividend and then the divisor arrive one after the other on data_in.
// The divisor is subtracted from a working remainder while the quotient
// counts up. A level start/done handshake connects the unit to the top level.
// Optional feature macro: REPDIV_ITER_COUNT_EN adds the iter_count output,
// which counts the edges spent in the subtract state.
module repdiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
`ifdef REPDIV_ITER_COUNT_EN
    ,
    output logic [WIDTH:0]   iter_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [WIDTH-1:0] r_divisor;
    logic             r_busy;
    logic             r_done;
    logic             r_divByZero;
`ifdef REPDIV_ITER_COUNT_EN
    logic [WIDTH:0]   r_iterCount;
`endif

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_divByZero;
`ifdef REPDIV_ITER_COUNT_EN
    assign iter_count  = r_iterCount;
`endif

    // Control FSM and datapath in one block. busy/done are registered to match the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divisor   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
`ifdef REPDIV_ITER_COUNT_EN
            r_iterCount <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LDA;
                        r_busy  <= 1'b1;
                    end
                end
                S_LDA: begin
                    r_remainder <= data_in;
                    r_state     <= S_LDB;
                end
                S_LDB: begin
                    r_divisor <= data_in;
`ifdef REPDIV_ITER_COUNT_EN
                    r_iterCount <= '0;
`endif
                    if (data_in == '0) begin
                        // A zero divisor finishes at once with a saturated quotient and the dividend kept.
                        r_quotient  <= '1;
                        r_divByZero <= 1'b1;
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_quotient  <= '0;
                        r_divByZero <= 1'b0;
                        r_state     <= S_SUB;
                    end
                end
                S_SUB: begin
`ifdef REPDIV_ITER_COUNT_EN
                    r_iterCount <= r_iterCount + (WIDTH+1)'(1);
`endif
                    if (r_remainder >= r_divisor) begin
                        r_remainder <= r_remainder - r_divisor;
                        r_quotient  <= r_quotient + WIDTH'(1);
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Stay here while start is still high, so each operation needs a fresh start pulse.
                    if (!start) begin
                        r_state     <= S_IDLE;
                        r_done      <= 1'b0;
                        r_divByZero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
